// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA sequencer: shifts at most STEP bits per cycle instead of a full barrel shifter.
// Latency: out_valid 1 + ceil(shamt/STEP) cycles after accept. Backpressure: holds result in DONE until out_ready.
// Build option SHIFT_SEQ_ROTATE_EN: op 11 becomes ROR; when undefined op 11 decodes as SLL.
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state, state_nxt;
    logic [31:0] acc, acc_nxt;
    logic [4:0]  rem, rem_nxt;
    logic [1:0]  op, op_nxt;
    logic [4:0]  k;
    logic [31:0] shifted;

    // rem never exceeds 31, so the STEP branch is only taken when STEP <= 31.
    always_comb begin
        k = ({1'b0, rem} < STEP_W) ? rem : 5'(STEP);
    end

    always_comb begin
        case (op)
            2'b01:   shifted = acc >> k;
            2'b10:   shifted = 32'($signed(acc) >>> k);
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11:   shifted = (acc >> k) | (acc << (6'd32 - {1'b0, k}));
`endif
            default: shifted = acc << k;
        endcase
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        op_nxt    = op;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nxt   = in_data;
                    rem_nxt   = in_shamt;
                    op_nxt    = in_op;
                    state_nxt = (in_shamt == 5'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                acc_nxt = shifted;
                rem_nxt = rem - k;
                if (rem == k) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // flush drops the operation but deliberately leaves acc (and out_data) untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            op    <= '0;
        end else if (flush) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            op    <= op_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);
    assign out_data  = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: STEP=4 main instance plus a STEP=1 instance for worst-case latency.
module tb_shift_sequencer;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    logic        s1_in_valid;
    logic        s1_in_ready;
    logic [1:0]  s1_in_op;
    logic [31:0] s1_in_data;
    logic [4:0]  s1_in_shamt;
    logic        s1_out_valid;
    logic        s1_out_ready;
    logic [31:0] s1_out_data;
    logic        s1_busy;
    logic        s1_flush;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    shift_sequencer #(.STEP(STEP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    shift_sequencer #(.STEP(1)) dut1 (
        .clk(clk), .rst(rst), .flush(s1_flush),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_op(s1_in_op),
        .in_data(s1_in_data), .in_shamt(s1_in_shamt),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
        .busy(s1_busy)
    );

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] r;
        case (o)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = $signed(d) >>> s;
`ifdef SHIFT_SEQ_ROTATE_EN
            default: r = (d >> s) | (d << (32 - int'(s)));
`else
            default: r = d << s;
`endif
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                          input int hold, input string name);
        int cnt;
        int exp_lat;
        exp_lat = 1 + (int'(s) + STEP - 1) / STEP;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL %s accept_timeout: in_ready=%b expected 1", name, in_ready);
            return;
        end
        in_valid = 1'b1; in_op = o; in_data = d; in_shamt = s;
        exp_q.push_back(model(o, d, s));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt <= 64) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_phase: busy=%b in_ready=%b expected busy=1 in_ready=0", name, busy, in_ready);
            end
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s result_timeout: out_valid=%b expected 1", name, out_valid);
            void'(exp_q.pop_back());
            return;
        end
        checks++;
        if (cnt !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, cnt, exp_lat);
        end
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== exp_q[0]) begin
                errors++;
                $display("FAIL %s hold%0d: out_valid=%b in_ready=%b busy=%b out_data=%h expected 1 0 1 %h",
                         name, i, out_valid, in_ready, busy, out_data, exp_q[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: in_ready=%b out_valid=%b busy=%b expected 1 0 0", name, in_ready, out_valid, busy);
        end
    endtask

    task automatic check_idle(input string name, input logic [31:0] exp_data);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== exp_data) begin
            errors++;
            $display("FAIL %s: in_ready=%b out_valid=%b busy=%b out_data=%h expected 1 0 0 %h",
                     name, in_ready, out_valid, busy, out_data, exp_data);
        end
    endtask

    task automatic start_long_sll();
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_data = 32'h1; in_shamt = 5'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        check_idle("reset_state", 32'h0);
        checks++;
        if (s1_in_ready !== 1'b1 || s1_out_valid !== 1'b0 || s1_busy !== 1'b0 || s1_out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state_step1: in_ready=%b out_valid=%b busy=%b out_data=%h",
                     s1_in_ready, s1_out_valid, s1_busy, s1_out_data);
        end
    endtask

    task automatic test_basic_sll();
        run_op(2'b00, 32'h0000_0001, 5'd5, 2, "basic_sll");
    endtask

    task automatic test_max_sra();
        run_op(2'b10, 32'h8000_0000, 5'd31, 0, "max_sra");
    endtask

    task automatic test_zero_shift();
        run_op(2'b01, 32'hDEAD_BEEF, 5'd0, 0, "zero_shift");
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'hF000_0000, 5'd4, 5, "backpressure");
        run_op(2'b00, 32'h1234_5678, 5'd3, 0, "back_to_back");
    endtask

    task automatic test_flush();
        start_long_sll();
        flush = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_precondition: busy=%b expected 1", busy);
        end
        @(negedge clk);
        flush = 1'b0;
        check_idle("flush_abort", 32'h0000_0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_result%0d: out_valid=%b expected 0", i, out_valid);
            end
        end
        run_op(2'b00, 32'h0000_0003, 5'd2, 0, "post_flush");
    endtask

    task automatic test_flush_with_request();
        in_valid = 1'b1; in_op = 2'b01; in_data = 32'hAAAA_5555; in_shamt = 5'd3;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check_idle("flush_blocks_accept", 32'h0000_000C);
    endtask

    task automatic test_reset_abort();
        start_long_sll();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_abort", 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_result%0d: out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_rotate();
        run_op(2'b11, 32'h0000_0001, 5'd1, 0, "rotate_op");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_step1_latency();
        int cnt;
        @(negedge clk);
        s1_in_valid = 1'b1; s1_in_op = 2'b10; s1_in_data = 32'h8000_0000; s1_in_shamt = 5'd31;
        @(posedge clk);
        @(negedge clk);
        s1_in_valid = 1'b0;
        cnt = 1;
        while (!s1_out_valid && cnt <= 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt !== 32) begin
            errors++;
            $display("FAIL step1_latency: got %0d cycles expected 32", cnt);
        end
        checks++;
        if (s1_out_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL step1_data: got %h expected ffffffff", s1_out_data);
        end
        s1_out_ready = 1'b1;
        @(negedge clk);
        s1_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_op = '0; in_data = '0; in_shamt = '0; out_ready = 1'b0;
        s1_in_valid = 1'b0; s1_in_op = '0; s1_in_data = '0; s1_in_shamt = '0;
        s1_out_ready = 1'b0; s1_flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic_sll();
        test_max_sra();
        test_zero_shift();
        test_back_to_back();
        test_flush();
        test_flush_with_request();
        test_reset_abort();
        test_rotate();
        test_random();
        test_step1_latency();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
